mem_access: RTL
===============

Name: mem_access

Overview:
- Memory-access stage of the 5-stage MIPS pipeline, combined with the MEM/WB pipeline register.
- Holds the data memory and performs byte/halfword/word loads and stores.
- Sign- or zero-extends load data.
- Registers everything the write-back stage consumes: mem_to_reg select, load data, ALU result, destination register, write enable.
- Includes a combinational word-read port for the debug unit.

Parameters:
- SIZE, 32, data/address width in bits.
- SIZE_REG_DIR, 5, register-file address width.
- MEM_DEPTH, 64, data memory depth in 32-bit words (power of two).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_stall  input  1  freezes the MEM/WB register and suppresses memory writes.
- i_mem_read  input  1  load instruction in MEM.
- i_mem_write  input  1  store instruction in MEM.
- i_width  input  2  access size: 00 byte, 01 halfword, 11 word; 10 treated as word.
- i_unsigned  input  1  1 = zero-extend loads (LBU/LHU), 0 = sign-extend.
- i_res_alu  input  SIZE  effective address / ALU result from EX/MEM.
- i_write_data  input  SIZE  store data (rt value); low bits used for SB/SH.
- i_reg_dst  input  SIZE_REG_DIR  destination register.
- i_reg_write  input  1  register-file write enable.
- i_mem_to_reg  input  1  write-back select.
- i_debug_addr  input  $clog2(MEM_DEPTH)  debug word index.
- o_mem_to_reg  output  1  registered i_mem_to_reg.
- o_data_read  output  SIZE  registered, extended load data.
- o_res_alu  output  SIZE  registered i_res_alu.
- o_reg_dst  output  SIZE_REG_DIR  registered i_reg_dst.
- o_reg_write  output  1  registered write enable (forced 0 on misaligned load).
- o_misaligned  output  1  registered flag: misaligned access in previous cycle.
- o_debug_data  output  SIZE  combinational word at i_debug_addr.

Behaviour:
- Reset (async, i_rst=1):
  - All registered outputs go to 0.
  - Every memory word cleared to 0.
  - Reset asserted mid-store discards that store.
- Addressing:
  - Word index = i_res_alu[$clog2(MEM_DEPTH)+1:2]. Upper bits ignored, so addresses wrap modulo 4*MEM_DEPTH bytes.
  - Byte lane = i_res_alu[1:0], little-endian: lane 0 = bits 7:0.
- Alignment:
  - Halfword requires addr[0]=0; word requires addr[1:0]=00.
  - A misaligned store is suppressed.
  - A misaligned load latches o_data_read=0 and o_reg_write=0.
  - Either case latches o_misaligned=1 for one cycle.
- Store:
  - Memory is written at the rising edge when i_mem_write=1, i_stall=0 and the access is aligned.
  - SB writes only the selected byte lane with i_write_data[7:0].
  - SH writes lanes {1,0} or {3,2} with i_write_data[15:0].
  - SW writes the full word.
- Load:
  - The memory word is read combinationally and the lane selected.
  - Byte/halfword are sign- or zero-extended per i_unsigned.
  - The result is captured in o_data_read at the same edge that captures the other MEM/WB fields, giving 1-cycle latency.
  - When i_mem_read=0, o_data_read still captures the extended read value; write_back ignores it via o_mem_to_reg.
- i_mem_read and i_mem_write both 1: the store is performed and the load captures the pre-write contents (read-before-write).
- Stall (i_stall=1):
  - All MEM/WB outputs hold their values.
  - No memory write occurs.
  - o_misaligned holds.
- Debug port: combinational, unaffected by stall. During a same-cycle store, it shows the old value until the edge.
- No internal FSM beyond the pipeline register. Store and load each complete in one cycle; no backpressure is generated.

Test Plan:
- Reset: write nonzero data, assert i_rst mid-cycle without a clock edge -> all outputs 0 immediately; o_debug_data=0 for every index.
- SW 0xDEADBEEF @0x10, then LW @0x10 -> next cycle o_data_read=0xDEADBEEF, o_reg_write=1; LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD.
- SB 0x12345677 @0x11 onto 0xDEADBEEF -> word at index 4 becomes 0xDEAD77EF; SH 0xAAAA5555 @0x12 -> 0x555577EF.
- Misaligned: LW @0x06 with i_reg_write=1 -> o_reg_write=0, o_data_read=0, o_misaligned=1 for one cycle; SH @0x05 -> memory unchanged.
- Stall: store presented with i_stall=1 -> memory unchanged and outputs held; deassert stall -> store lands and outputs update on the next edge.
- Wrap: SW 0x0000CAFE @0x100 with MEM_DEPTH=64 -> o_debug_data at index 0 = 0x0000CAFE.

Source files
------------

// File: rtl/mem_access.sv
// MIPS memory-access stage with data memory and MEM/WB pipeline register.
// Latency: stores commit at the edge; load data and WB fields appear 1 cycle later.
// Backpressure: none generated; i_stall freezes MEM/WB state and blocks memory writes.
module mem_access #(
  parameter int SIZE         = 32,
  parameter int SIZE_REG_DIR = 5,
  parameter int MEM_DEPTH    = 64
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_stall,
  input  logic                         i_mem_read,
  input  logic                         i_mem_write,
  input  logic [1:0]                   i_width,
  input  logic                         i_unsigned,
  input  logic [SIZE-1:0]              i_res_alu,
  input  logic [SIZE-1:0]              i_write_data,
  input  logic [SIZE_REG_DIR-1:0]      i_reg_dst,
  input  logic                         i_reg_write,
  input  logic                         i_mem_to_reg,
  input  logic [$clog2(MEM_DEPTH)-1:0] i_debug_addr,
  output logic                         o_mem_to_reg,
  output logic [SIZE-1:0]              o_data_read,
  output logic [SIZE-1:0]              o_res_alu,
  output logic [SIZE_REG_DIR-1:0]      o_reg_dst,
  output logic                         o_reg_write,
  output logic                         o_misaligned,
  output logic [SIZE-1:0]              o_debug_data
);

  localparam int AW = $clog2(MEM_DEPTH);

  // Data memory, one 32-bit little-endian word per entry.
  logic [SIZE-1:0] r_mem [MEM_DEPTH];

  // MEM/WB pipeline register.
  logic                    r_mem_to_reg;
  logic [SIZE-1:0]         r_data_read;
  logic [SIZE-1:0]         r_res_alu;
  logic [SIZE_REG_DIR-1:0] r_reg_dst;
  logic                    r_reg_write;
  logic                    r_misaligned;

  // Address decode: upper address bits are ignored so accesses wrap.
  logic [AW-1:0]   w_word_idx;
  logic [1:0]      w_lane;
  logic [SIZE-1:0] w_word;
  logic [SIZE-1:0] w_lane_shifted;
  logic            w_misaligned_addr;
  logic            w_access_mis;
  logic            w_load_mis;
  logic            w_we;
  logic [3:0]      w_be;
  logic [SIZE-1:0] w_wdata;
  logic [SIZE-1:0] w_load_val;

  assign w_word_idx     = i_res_alu[AW+1:2];
  assign w_lane         = i_res_alu[1:0];
  assign w_word         = r_mem[w_word_idx];
  // Halfwords pick lane 0 or 2, so clear the low lane bit for them.
  assign w_lane_shifted = (i_width == 2'b01) ? (w_word >> {w_lane[1], 4'b0000})
                                             : (w_word >> {w_lane, 3'b000});

  // Alignment rule per access size; 10 behaves like a word.
  always_comb begin
    w_misaligned_addr = 1'b0;
    case (i_width)
      2'b00:   w_misaligned_addr = 1'b0;
      2'b01:   w_misaligned_addr = w_lane[0];
      default: w_misaligned_addr = |w_lane;
    endcase
  end

  assign w_access_mis = (i_mem_read | i_mem_write) & w_misaligned_addr;
  assign w_load_mis   = i_mem_read & w_misaligned_addr;
  assign w_we         = i_mem_write & ~i_stall & ~w_misaligned_addr;

  // Store lane enables and lane-replicated store data.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = i_write_data;
    case (i_width)
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{i_write_data[7:0]}};
      end
      2'b01: begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_write_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane select plus sign/zero extension of load data.
  always_comb begin
    w_load_val = w_word;
    case (i_width)
      2'b00: w_load_val = i_unsigned ? {24'b0, w_lane_shifted[7:0]}
                                     : {{24{w_lane_shifted[7]}}, w_lane_shifted[7:0]};
      2'b01: w_load_val = i_unsigned ? {16'b0, w_lane_shifted[15:0]}
                                     : {{16{w_lane_shifted[15]}}, w_lane_shifted[15:0]};
      default: w_load_val = w_word;
    endcase
  end

  // Data memory: cleared by reset, byte-lane writes for aligned, unstalled stores.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_word_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  // MEM/WB register; a misaligned load kills its data and register write.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem_to_reg <= 1'b0;
      r_data_read  <= '0;
      r_res_alu    <= '0;
      r_reg_dst    <= '0;
      r_reg_write  <= 1'b0;
      r_misaligned <= 1'b0;
    end else if (!i_stall) begin
      r_mem_to_reg <= i_mem_to_reg;
      r_data_read  <= w_load_mis ? '0 : w_load_val;
      r_res_alu    <= i_res_alu;
      r_reg_dst    <= i_reg_dst;
      r_reg_write  <= i_reg_write & ~w_load_mis;
      r_misaligned <= w_access_mis;
    end
  end

  assign o_mem_to_reg = r_mem_to_reg;
  assign o_data_read  = r_data_read;
  assign o_res_alu    = r_res_alu;
  assign o_reg_dst    = r_reg_dst;
  assign o_reg_write  = r_reg_write;
  assign o_misaligned = r_misaligned;
  assign o_debug_data = r_mem[i_debug_addr];

endmodule
